// File: rtl/zz_pkg.sv
// zz_pkg: shared symbol codes, FSM states, widths and the JPEG magnitude encoder
package zz_pkg;
    localparam int BLK_LEN = 64;
    localparam int COEF_W = 9;
    localparam int AMP_W = 9;
    typedef enum logic [1:0] {SYM_DC = 2'd0, SYM_AC = 2'd1, SYM_ZRL = 2'd2, SYM_EOB = 2'd3} sym_t;
    typedef enum logic [1:0] {ST_IDLE, ST_DC, ST_AC, ST_DONE} state_t;
    function automatic logic [3:0] mag_size(input logic signed [COEF_W:0] v);
        logic [COEF_W:0] m;
        m = v[COEF_W] ? -v : v;
        mag_size = '0;
        for (int i = 0; i <= COEF_W; i++)
            if (m[i]) mag_size = 4'(i + 1);
        return mag_size;
    endfunction
    // negative values are sent one's-complemented in the low size bits
    function automatic logic [AMP_W-1:0] mag_amp(input logic signed [COEF_W:0] v, input logic [3:0] s);
        logic [COEF_W:0] t;
        t = v[COEF_W] ? v - 10'sd1 : v;
        return t[AMP_W-1:0] & AMP_W'((10'd1 << s) - 10'd1);
    endfunction
endpackage

// File: rtl/zigzag_rom.sv
// zigzag_rom: JPEG zigzag scan index to raster address
module zigzag_rom (
    input  logic [5:0] idx,
    output logic [5:0] raster
);
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };
    assign raster = ZZ[idx];
endmodule

// File: rtl/zigzag_rle.sv
// zigzag_rle: ping-pong block capture, zigzag rescan and DC/AC/ZRL/EOB run-length symbol emission
module zigzag_rle
    import zz_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [8:0] dctq,
    input  logic       dctq_valid,
    input  logic [5:0] addr,
    output logic       hold,
    output logic       sym_valid,
    input  logic       sym_ready,
    output logic [1:0] sym_type,
    output logic [3:0] run,
    output logic [3:0] size,
    output logic [8:0] amp
);
    logic [COEF_W-1:0] mem [2*BLK_LEN];
    logic [1:0] full, full_n;
    logic wr_bank, rd_bank, we, wr_done, release_bank, begin_blk;
    logic act, dv, fetch, consume, emit, free_out;
    logic [5:0] cnt, k, raster, zeros, zeros_n;
    logic [COEF_W-1:0] rdata, prev_dc;
    logic signed [COEF_W:0] val;
    logic [3:0] e_run, e_size;
    sym_t e_type;
    state_t st, st_n;

    zigzag_rom u_rom (.idx(k), .raster(raster));

    assign we = dctq_valid && !hold;
    assign wr_done = we && cnt == 6'd63;
    assign free_out = !sym_valid || sym_ready;
    // fetch stage: k addresses the RAM, rdata/dv hold the coefficient under evaluation
    assign fetch = act && (!dv || consume);
    assign e_size = mag_size(val);

    always_comb begin
        full_n = full;
        if (wr_done) full_n[wr_bank] = 1'b1;
        if (release_bank) full_n[rd_bank] = 1'b0;
    end

    always_comb begin
        st_n = st;
        zeros_n = zeros;
        emit = 1'b0;
        e_type = SYM_DC;
        e_run = '0;
        val = '0;
        consume = 1'b0;
        release_bank = 1'b0;
        begin_blk = 1'b0;
        case (st)
            ST_IDLE: if (full[rd_bank]) begin
                begin_blk = 1'b1;
                st_n = ST_DC;
            end
            ST_DC: if (dv && free_out) begin
                emit = 1'b1;
                consume = 1'b1;
                val = $signed({rdata[8], rdata}) - $signed({prev_dc[8], prev_dc});
                st_n = ST_AC;
            end
            ST_AC: if (dv && free_out) begin
                if (rdata == '0) begin
                    consume = 1'b1;
                    zeros_n = zeros + 6'd1;
                end else if (zeros >= 6'd16) begin
                    emit = 1'b1;
                    e_type = SYM_ZRL;
                    e_run = 4'd15;
                    zeros_n = zeros - 6'd16;
                end else begin
                    emit = 1'b1;
                    consume = 1'b1;
                    e_type = SYM_AC;
                    e_run = zeros[3:0];
                    val = $signed({rdata[8], rdata});
                    zeros_n = '0;
                end
                // act has already dropped once coefficient 63 sits in rdata
                if (consume && !act) st_n = ST_DONE;
            end
            default: if (free_out) begin
                emit = zeros != '0;
                e_type = SYM_EOB;
                zeros_n = '0;
                release_bank = 1'b1;
                st_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) mem[{wr_bank, addr}] <= dctq;
        if (fetch) rdata <= mem[{rd_bank, raster}];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            cnt <= '0;
            hold <= 1'b0;
            st <= ST_IDLE;
            act <= 1'b0;
            k <= '0;
            dv <= 1'b0;
            prev_dc <= '0;
            zeros <= '0;
            sym_valid <= 1'b0;
            sym_type <= '0;
            run <= '0;
            size <= '0;
            amp <= '0;
        end else begin
            full <= full_n;
            hold <= full_n[wr_bank ^ wr_done];
            wr_bank <= wr_bank ^ wr_done;
            cnt <= cnt + 6'(we);
            rd_bank <= rd_bank ^ release_bank;
            st <= st_n;
            act <= begin_blk || (act && !(fetch && k == 6'd63));
            k <= begin_blk ? '0 : k + 6'(fetch);
            dv <= fetch || (dv && !consume);
            zeros <= zeros_n;
            if (st == ST_IDLE && start) prev_dc <= '0;
            else if (st == ST_DC && consume) prev_dc <= rdata;
            if (free_out) begin
                sym_valid <= emit;
                if (emit) begin
                    sym_type <= e_type;
                    run <= e_run;
                    size <= e_size;
                    amp <= mag_amp(val, e_size);
                end
            end
        end
    end
endmodule
